stopwatch_key_ctrl: RTL and testbench
=====================================

Name: stopwatch_key_ctrl

Overview:
Front-end key conditioner and run-control stage feeding the stopwatch counter/display block on the DE1-SoC.
- Takes the three raw active-low board keys (reset, start/pause, display-stop), synchronises and debounces each one, and emits one-cycle press pulses.
- Maintains the two control states the stopwatch consumes: counter_work (timing runs) and display_work (display registers follow live count).

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a sampled key level must differ from the accepted level before it is accepted (20 ms at 50 MHz); legal range 2..2^CNT_W.
CNT_W, 20, width of each per-key debounce counter.

Ports:
clk  input  1  system clock, 50 MHz, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
key_reset_n  input  1  raw board key, 0 = pressed, asynchronous to clk
key_start_pause_n  input  1  raw board key, 0 = pressed
key_display_stop_n  input  1  raw board key, 0 = pressed
key_level  output  3  debounced pressed levels, 1 = held; [0] reset key, [1] start/pause, [2] display-stop
clr_pulse  output  1  one-cycle pulse on debounced press of reset key
start_pause_pulse  output  1  one-cycle pulse on debounced press of start/pause key
display_stop_pulse  output  1  one-cycle pulse on debounced press of display-stop key
counter_work  output  1  1 = stopwatch counting
display_work  output  1  1 = display follows counters, 0 = display frozen

Behaviour:
- Reset values: sync flops 1 (released); key_level 3'b000; all pulses 0; debounce counters 0; counter_work 0; display_work 1.
- Synchroniser: two flops per key, then invert, giving sp[i] (1 = pressed). sp[i] reflects raw key at edge N+1 when first sampled at edge N.
- Debounce, per channel, independent:
  - sp[i] == key_level[i]: counter cleared to 0.
  - sp[i] != key_level[i] and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sp[i] != key_level[i] and counter == DEBOUNCE_CYCLES-1: key_level[i] <= sp[i], counter <= 0.
  - Any return to agreement before the terminal count restarts the count from 0, so glitches shorter than DEBOUNCE_CYCLES cycles are ignored.
- Pulses: asserted in the same cycle key_level[i] transitions 0->1; high for exactly one cycle.
  - Release (1->0) produces no pulse.
  - Holding a key never re-pulses.
- Latency: raw key held low from edge 0 gives key_level and pulse high after edge DEBOUNCE_CYCLES+1.
- Control update, registered, visible the cycle after the pulse. Priority clr > start_pause > display_stop when pulses coincide:
  - clr_pulse: counter_work <= 0, display_work <= 1.
  - start_pause_pulse: counter_work <= ~counter_work. Resuming (0->1) also forces display_work <= 1; pausing leaves display_work unchanged.
  - display_stop_pulse: display_work <= ~display_work only when counter_work == 1; ignored while paused.
- Reset asserted mid-debounce or mid-pulse: all state returns to reset values asynchronously. A key still held at reset release is re-debounced from 0 and produces a fresh pulse.
- Counter width: CNT_W must hold DEBOUNCE_CYCLES-1. No wrap occurs because the counter clears at the terminal count.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
1. Reset asserted then released, keys high -> key_level=000, pulses 0, counter_work=0, display_work=1 for 20 cycles.
2. key_start_pause_n low from edge 0, held 20 cycles -> start_pause_pulse high only in cycle after edge 5, key_level[1]=1 from then; counter_work=1 after edge 6. Release -> key_level[1]=0 four cycles after sync, no pulse.
3. key_display_stop_n low for 3 cycles, high 2, low 3 (bounce) -> no pulse, key_level[2] stays 0. Then low 10 cycles -> one display_stop_pulse; display_work toggles 1->0 only if counter_work=1, else unchanged.
4. Run, freeze display (display_work=0), press start/pause twice -> first press counter_work=0 with display_work still 0; second press counter_work=1 and display_work=1.
5. Reset key and start/pause key driven low on the same edge, held 10 cycles -> clr_pulse and start_pause_pulse coincide; result counter_work=0, display_work=1.
6. key_reset_n held low; assert reset at debounce count 2, release -> counter cleared. clr_pulse fires after edge 5 counted from release, not earlier.

Source files
------------

// File: rtl/stopwatch_key_ctrl_if.sv
// Key and run-control signal bundle between the DE1-SoC key inputs and the
// stopwatch counter/display block.
interface stopwatch_key_ctrl_if;
  logic       key_reset_n;
  logic       key_start_pause_n;
  logic       key_display_stop_n;
  logic [2:0] key_level;
  logic       clr_pulse;
  logic       start_pause_pulse;
  logic       display_stop_pulse;
  logic       counter_work;
  logic       display_work;

  modport master (
    output key_reset_n, key_start_pause_n, key_display_stop_n,
    input  key_level, clr_pulse, start_pause_pulse, display_stop_pulse,
    input  counter_work, display_work
  );

  modport slave (
    input  key_reset_n, key_start_pause_n, key_display_stop_n,
    output key_level, clr_pulse, start_pause_pulse, display_stop_pulse,
    output counter_work, display_work
  );
endinterface

// File: rtl/stopwatch_key_ctrl.sv
// Synchronises and debounces the three board keys, emits press pulses and
// keeps the stopwatch run (counter_work) and display-follow (display_work) state.
module stopwatch_key_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  stopwatch_key_ctrl_if.slave  kbus
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       w_raw_n;
  logic [2:0]       w_sp;
  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [CNT_W-1:0] r_cnt [3];
  logic [2:0]       r_level;
  logic [2:0]       r_pulse;
  logic             r_counter_work;
  logic             r_display_work;
  logic             w_counter_work_nxt;
  logic             w_display_work_nxt;

  assign w_raw_n = {kbus.key_display_stop_n, kbus.key_start_pause_n, kbus.key_reset_n};
  assign w_sp    = ~r_sync2;

  // Two-flop synchronisers; idle level is released (1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
    end else begin
      r_sync1 <= w_raw_n;
      r_sync2 <= r_sync1;
    end
  end

  // Per-key debounce; a level is accepted only after DEBOUNCE_CYCLES
  // consecutive disagreeing samples, and a 0->1 acceptance yields the pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level <= 3'b000;
      r_pulse <= 3'b000;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_pulse[i] <= 1'b0;
        if (w_sp[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == TERM) begin
          r_cnt[i]   <= '0;
          r_level[i] <= w_sp[i];
          r_pulse[i] <= w_sp[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Run-control next state; clear beats start/pause beats display-stop.
  always_comb begin
    w_counter_work_nxt = r_counter_work;
    w_display_work_nxt = r_display_work;
    if (r_pulse[0]) begin
      w_counter_work_nxt = 1'b0;
      w_display_work_nxt = 1'b1;
    end else if (r_pulse[1]) begin
      w_counter_work_nxt = ~r_counter_work;
      if (!r_counter_work) w_display_work_nxt = 1'b1;
    end else if (r_pulse[2] && r_counter_work) begin
      w_display_work_nxt = ~r_display_work;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_counter_work <= 1'b0;
      r_display_work <= 1'b1;
    end else begin
      r_counter_work <= w_counter_work_nxt;
      r_display_work <= w_display_work_nxt;
    end
  end

  assign kbus.key_level          = r_level;
  assign kbus.clr_pulse          = r_pulse[0];
  assign kbus.start_pause_pulse  = r_pulse[1];
  assign kbus.display_stop_pulse = r_pulse[2];
  assign kbus.counter_work       = r_counter_work;
  assign kbus.display_work       = r_display_work;

endmodule

// File: tb/tb_stopwatch_key_ctrl.sv
// Bench for stopwatch_key_ctrl: directed key scenarios plus random key bouncing,
// every cycle compared against a sliding-window reference model.
module tb_stopwatch_key_ctrl;

  localparam int DEB = 4;

  logic clk;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;
  bit   mon_en  = 0;

  stopwatch_key_ctrl_if kbus ();

  stopwatch_key_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .kbus  (kbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a key level is accepted once the most recent DEB
  // synchronised samples all differ from it.
  logic [2:0]     m_s1, m_s2, m_lev, m_pul, m_npul, m_sp;
  logic           m_cw, m_dw;
  logic [DEB-1:0] m_hist [3];
  int             m_nv [3];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s1 = 3'b111; m_s2 = 3'b111; m_lev = 3'b000; m_pul = 3'b000;
      m_cw = 1'b0; m_dw = 1'b1;
      for (int i = 0; i < 3; i++) begin m_hist[i] = '0; m_nv[i] = 0; end
    end else begin
      if (m_pul[0]) begin
        m_cw = 1'b0; m_dw = 1'b1;
      end else if (m_pul[1]) begin
        if (!m_cw) m_dw = 1'b1;
        m_cw = ~m_cw;
      end else if (m_pul[2]) begin
        if (m_cw) m_dw = ~m_dw;
      end
      m_sp   = ~m_s2;
      m_npul = 3'b000;
      for (int i = 0; i < 3; i++) begin
        m_hist[i] = {m_hist[i][DEB-2:0], m_sp[i]};
        if (m_nv[i] < DEB) m_nv[i]++;
        if (m_nv[i] == DEB && m_hist[i] == {DEB{~m_lev[i]}}) begin
          m_lev[i]  = m_sp[i];
          m_npul[i] = m_sp[i];
        end
      end
      m_pul = m_npul;
      m_s2  = m_s1;
      m_s1  = {kbus.key_display_stop_n, kbus.key_start_pause_n, kbus.key_reset_n};
    end
  end

  always @(negedge clk) begin
    if (mon_en)
      chk("cycle", 32'({kbus.key_level, kbus.clr_pulse, kbus.start_pause_pulse,
                        kbus.display_stop_pulse, kbus.counter_work, kbus.display_work}),
                   32'({m_lev, m_pul[0], m_pul[1], m_pul[2], m_cw, m_dw}));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // kn = {display_stop_n, start_pause_n, reset_n}
  task automatic keys(input logic [2:0] kn);
    kbus.key_reset_n        = kn[0];
    kbus.key_start_pause_n  = kn[1];
    kbus.key_display_stop_n = kn[2];
  endtask

  initial begin
    reset = 1'b1;
    keys(3'b111);
    tick(2);
    mon_en = 1;
    chk("rst_level", 32'(kbus.key_level), 32'd0);
    chk("rst_dw", 32'(kbus.display_work), 32'd1);
    reset = 1'b0;
    tick(20);
    chk("idle_level", 32'(kbus.key_level), 32'd0);
    chk("idle_cw", 32'(kbus.counter_work), 32'd0);
    chk("idle_dw", 32'(kbus.display_work), 32'd1);

    // Start/pause press: pulse after edge 5, run after edge 6
    keys(3'b101);
    tick(5);
    chk("sp_early", 32'(kbus.start_pause_pulse), 32'd0);
    tick(1);
    chk("sp_pulse", 32'(kbus.start_pause_pulse), 32'd1);
    chk("sp_level", 32'(kbus.key_level[1]), 32'd1);
    tick(1);
    chk("sp_once", 32'(kbus.start_pause_pulse), 32'd0);
    chk("sp_run", 32'(kbus.counter_work), 32'd1);
    tick(13);
    keys(3'b111);
    tick(5);
    chk("sp_rel_hold", 32'(kbus.key_level[1]), 32'd1);
    tick(1);
    chk("sp_rel", 32'(kbus.key_level[1]), 32'd0);
    tick(10);

    // Bounce on display-stop is ignored, then a clean press freezes display
    keys(3'b011); tick(3);
    keys(3'b111); tick(2);
    keys(3'b011); tick(3);
    keys(3'b111); tick(8);
    chk("ds_bounce", 32'(kbus.key_level[2]), 32'd0);
    chk("ds_bounce_dw", 32'(kbus.display_work), 32'd1);
    keys(3'b011); tick(10);
    keys(3'b111); tick(10);
    chk("ds_freeze", 32'(kbus.display_work), 32'd0);

    // Pause keeps frozen display; resume forces display on
    keys(3'b101); tick(10); keys(3'b111); tick(10);
    chk("pause_cw", 32'(kbus.counter_work), 32'd0);
    chk("pause_dw", 32'(kbus.display_work), 32'd0);
    keys(3'b011); tick(10); keys(3'b111); tick(10);
    chk("ds_paused_dw", 32'(kbus.display_work), 32'd0);
    keys(3'b101); tick(10); keys(3'b111); tick(10);
    chk("resume_cw", 32'(kbus.counter_work), 32'd1);
    chk("resume_dw", 32'(kbus.display_work), 32'd1);

    // Clear and start/pause coincide: clear wins
    keys(3'b100); tick(6);
    chk("co_clr", 32'(kbus.clr_pulse), 32'd1);
    chk("co_sp", 32'(kbus.start_pause_pulse), 32'd1);
    tick(4); keys(3'b111); tick(10);
    chk("co_cw", 32'(kbus.counter_work), 32'd0);
    chk("co_dw", 32'(kbus.display_work), 32'd1);

    // Reset mid-debounce of a held clear key restarts the count
    keys(3'b110); tick(4);
    reset = 1'b1; tick(1);
    chk("mid_rst_level", 32'(kbus.key_level), 32'd0);
    reset = 1'b0;
    tick(5);
    chk("clr_not_early", 32'(kbus.clr_pulse), 32'd0);
    tick(1);
    chk("clr_after_rel", 32'(kbus.clr_pulse), 32'd1);
    tick(3); keys(3'b111); tick(10);

    // Random bouncing keys with occasional asynchronous resets
    for (int s = 0; s < 600; s++) begin
      keys(3'($urandom));
      if ($urandom_range(0, 39) == 0) begin
        #2 reset = 1'b1;
        tick(1);
        reset = 1'b0;
      end
      tick($urandom_range(1, 8));
    end
    keys(3'b111);
    tick(10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
